c7bexu_lsu_ctl: RTL and testbench

Load/store control unit. Accepts one memory op per request from the EXU E stage, checks alignment in LS1, performs a single-beat bus transaction in LS2, and returns a completion pulse in LS3. Its completion signals drive the EXU execution-control stall logic. That logic holds the pipeline stalled from `lsu_vld_e` until the ALE, load-data or write-finish pulse.

---
 rtl/c7bexu_lsu_ctl_pkg.sv | 19 +
 rtl/c7bexu_lsu_align.sv | 43 ++++
 rtl/c7bexu_lsu_ctl.sv | 130 +++++++++++++
 tb/tb_c7bexu_lsu_ctl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/c7bexu_lsu_ctl_pkg.sv
// Shared encodings for the LSU control slice: op-field bit positions,
// access-size codes and FSM states.
package c7bexu_lsu_ctl_pkg;

   localparam int OP_ST  = 3;
   localparam int OP_UNS = 2;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LS1  = 2'd1,
      S_LS2  = 2'd2,
      S_LS3  = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/c7bexu_lsu_align.sv
// Combinational datapath: alignment check, byte-lane strobes, store-data
// replication and load extract/extend.
module c7bexu_lsu_align
   import c7bexu_lsu_ctl_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [1:0]  a_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic        misal_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic        is_b, is_h, sx;
   logic [31:0] sh;

   assign is_b = (op_i[1:0] == SZ_B);
   assign is_h = (op_i[1:0] == SZ_H);
   assign sx   = ~op_i[OP_UNS];

   always_comb begin
      misal_o = is_h ? a_i[0] : (!is_b && (a_i != 2'b00));
      sh      = rdata_i >> {a_i, 3'b000};
      if (is_b) begin
         wstrb_o = 4'b0001 << a_i;
         wdata_o = {4{wdata_i[7:0]}};
         rdata_o = {{24{sh[7] & sx}}, sh[7:0]};
      end else if (is_h) begin
         wstrb_o = 4'b0011 << a_i;
         wdata_o = {2{wdata_i[15:0]}};
         rdata_o = {{16{sh[15] & sx}}, sh[15:0]};
      end else begin
         // Reserved size 2'b11 falls through here and behaves as a word.
         wstrb_o = 4'b1111;
         wdata_o = wdata_i;
         rdata_o = sh;
      end
      if (!op_i[OP_ST]) wstrb_o = 4'b0000;
   end

endmodule

// File: rtl/c7bexu_lsu_ctl.sv
// LSU control: E capture -> LS1 alignment -> LS2 single-beat bus -> LS3 completion.
// The LS3 pulse (or ALE) is what releases the EXU stall, so every op ends in one.
module c7bexu_lsu_ctl
   import c7bexu_lsu_ctl_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          lsu_vld_e,
   input  logic [3:0]    lsu_op_e,
   input  logic [AW-1:0] lsu_addr_e,
   input  logic [31:0]   lsu_wdata_e,
   input  logic [4:0]    lsu_rd_e,
   output logic          lsu_except_ale_ls1,
   output logic [AW-1:0] lsu_badv_ls1,
   output logic          lsu_data_valid_ls3,
   output logic [31:0]   lsu_rdata_ls3,
   output logic [4:0]    lsu_rd_ls3,
   output logic          lsu_wr_fin_ls3,
   output logic          lsu_except_buserr_ls3,
   output logic          biu_req,
   output logic          biu_wr,
   output logic [AW-1:0] biu_addr,
   output logic [3:0]    biu_wstrb,
   output logic [31:0]   biu_wdata,
   input  logic          biu_ack,
   input  logic [31:0]   biu_rdata,
   input  logic          biu_err
);

   lsu_state_e    state_q;
   logic [3:0]    op_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [4:0]    rd_q;
   logic          bwr_q;
   logic [AW-1:0] baddr_q;
   logic [3:0]    bstrb_q;
   logic [31:0]   bwdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic          misal;
   logic [3:0]    wstrb_d;
   logic [31:0]   wdata_d;
   logic [31:0]   rdata_d;
   logic          capture;

   // op/addr stay frozen from LS1 through LS3, so one align instance
   // serves both the LS1 store path and the LS2 load extract.
   c7bexu_lsu_align u_align (
      .op_i    (op_q),
      .a_i     (addr_q[1:0]),
      .wdata_i (wdata_q),
      .rdata_i (biu_rdata),
      .misal_o (misal),
      .wstrb_o (wstrb_d),
      .wdata_o (wdata_d),
      .rdata_o (rdata_d)
   );

   assign capture = lsu_vld_e && (state_q == S_IDLE || state_q == S_LS3);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= '0;
         bwr_q    <= 1'b0;
         baddr_q  <= '0;
         bstrb_q  <= '0;
         bwdata_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (capture) begin
            op_q    <= lsu_op_e;
            addr_q  <= lsu_addr_e;
            wdata_q <= lsu_wdata_e;
            rd_q    <= lsu_rd_e;
         end
         case (state_q)
            S_IDLE: if (capture) state_q <= S_LS1;
            S_LS1: begin
               if (misal) begin
                  state_q <= S_IDLE;
               end else begin
                  bwr_q    <= op_q[OP_ST];
                  baddr_q  <= {addr_q[AW-1:2], 2'b00};
                  bstrb_q  <= wstrb_d;
                  bwdata_q <= wdata_d;
                  state_q  <= S_LS2;
               end
            end
            S_LS2: begin
               if (biu_ack) begin
                  rdata_q <= (biu_err || op_q[OP_ST]) ? 32'h0 : rdata_d;
                  err_q   <= biu_err;
                  state_q <= S_LS3;
               end
            end
            S_LS3: state_q <= capture ? S_LS1 : S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign lsu_except_ale_ls1    = (state_q == S_LS1) && misal;
   assign lsu_badv_ls1          = lsu_except_ale_ls1 ? addr_q : '0;
   assign lsu_data_valid_ls3    = (state_q == S_LS3) && !op_q[OP_ST];
   assign lsu_wr_fin_ls3        = (state_q == S_LS3) && op_q[OP_ST];
   assign lsu_except_buserr_ls3 = (state_q == S_LS3) && err_q;
   assign lsu_rdata_ls3         = rdata_q;
   assign lsu_rd_ls3            = rd_q;

   // Decoded from state so an async reset drops the request in the same cycle.
   assign biu_req   = (state_q == S_LS2);
   assign biu_wr    = bwr_q;
   assign biu_addr  = baddr_q;
   assign biu_wstrb = bstrb_q;
   assign biu_wdata = bwdata_q;

   a_no_vld_busy: assert property (@(posedge clk) disable iff (!resetn)
      !(lsu_vld_e && (state_q == S_LS1 || state_q == S_LS2)));

endmodule

// File: tb/tb_c7bexu_lsu_ctl.sv
// Directed bench for c7bexu_lsu_ctl: vector table plus back-to-back,
// stray-ack and reset-in-LS2 sequences.
module tb_c7bexu_lsu_ctl;

   logic        clk;
   logic        resetn;
   logic        lsu_vld_e;
   logic [3:0]  lsu_op_e;
   logic [31:0] lsu_addr_e;
   logic [31:0] lsu_wdata_e;
   logic [4:0]  lsu_rd_e;
   logic        lsu_except_ale_ls1;
   logic [31:0] lsu_badv_ls1;
   logic        lsu_data_valid_ls3;
   logic [31:0] lsu_rdata_ls3;
   logic [4:0]  lsu_rd_ls3;
   logic        lsu_wr_fin_ls3;
   logic        lsu_except_buserr_ls3;
   logic        biu_req;
   logic        biu_wr;
   logic [31:0] biu_addr;
   logic [3:0]  biu_wstrb;
   logic [31:0] biu_wdata;
   logic        biu_ack;
   logic [31:0] biu_rdata;
   logic        biu_err;

   int errors = 0;
   int checks = 0;

   c7bexu_lsu_ctl #(.AW(32), .DW(32)) dut (
      .clk(clk), .resetn(resetn),
      .lsu_vld_e(lsu_vld_e), .lsu_op_e(lsu_op_e), .lsu_addr_e(lsu_addr_e),
      .lsu_wdata_e(lsu_wdata_e), .lsu_rd_e(lsu_rd_e),
      .lsu_except_ale_ls1(lsu_except_ale_ls1), .lsu_badv_ls1(lsu_badv_ls1),
      .lsu_data_valid_ls3(lsu_data_valid_ls3), .lsu_rdata_ls3(lsu_rdata_ls3),
      .lsu_rd_ls3(lsu_rd_ls3), .lsu_wr_fin_ls3(lsu_wr_fin_ls3),
      .lsu_except_buserr_ls3(lsu_except_buserr_ls3),
      .biu_req(biu_req), .biu_wr(biu_wr), .biu_addr(biu_addr),
      .biu_wstrb(biu_wstrb), .biu_wdata(biu_wdata),
      .biu_ack(biu_ack), .biu_rdata(biu_rdata), .biu_err(biu_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        err;
      int          waits;
      logic        ale;
      logic [31:0] baddr;
      logic [3:0]  strb;
      logic [31:0] bwdata;
      logic [31:0] erdata;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ale"},    {31'd0, lsu_except_ale_ls1}, 32'd0);
      chk({tag, ".badv"},   lsu_badv_ls1, 32'd0);
      chk({tag, ".dv"},     {31'd0, lsu_data_valid_ls3}, 32'd0);
      chk({tag, ".rdata"},  lsu_rdata_ls3, 32'd0);
      chk({tag, ".rd"},     {27'd0, lsu_rd_ls3}, 32'd0);
      chk({tag, ".wrfin"},  {31'd0, lsu_wr_fin_ls3}, 32'd0);
      chk({tag, ".buserr"}, {31'd0, lsu_except_buserr_ls3}, 32'd0);
      chk({tag, ".req"},    {31'd0, biu_req}, 32'd0);
      chk({tag, ".wr"},     {31'd0, biu_wr}, 32'd0);
      chk({tag, ".baddr"},  biu_addr, 32'd0);
      chk({tag, ".strb"},   {28'd0, biu_wstrb}, 32'd0);
      chk({tag, ".bwdata"}, biu_wdata, 32'd0);
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
      lsu_vld_e   = 1'b1;
      lsu_op_e    = op;
      lsu_addr_e  = addr;
      lsu_wdata_e = wdata;
      lsu_rd_e    = rd;
   endtask

   // Called at posedge+1 in IDLE; returns at posedge+1 in IDLE.
   task automatic run_vec(input int idx, input vec_t v);
      string t;
      logic  st;
      t  = $sformatf("v%0d", idx);
      st = v.op[3];
      issue(v.op, v.addr, v.wdata, v.rd);
      step();
      lsu_vld_e = 1'b0;
      chk({t, ".ale"}, {31'd0, lsu_except_ale_ls1}, {31'd0, v.ale});
      chk({t, ".req_ls1"}, {31'd0, biu_req}, 32'd0);
      if (v.ale) begin
         chk({t, ".badv"}, lsu_badv_ls1, v.addr);
         step();
         chk({t, ".req_after_ale"}, {31'd0, biu_req}, 32'd0);
         chk({t, ".ale_once"}, {31'd0, lsu_except_ale_ls1}, 32'd0);
         chk({t, ".no_pulse"}, {30'd0, lsu_data_valid_ls3, lsu_wr_fin_ls3}, 32'd0);
         return;
      end
      step();
      chk({t, ".req"},   {31'd0, biu_req}, 32'd1);
      chk({t, ".wr"},    {31'd0, biu_wr}, {31'd0, st});
      chk({t, ".baddr"}, biu_addr, v.baddr);
      chk({t, ".strb"},  {28'd0, biu_wstrb}, {28'd0, v.strb});
      if (st) chk({t, ".bwdata"}, biu_wdata, v.bwdata);
      for (int w = 0; w < v.waits; w++) begin
         step();
         chk({t, ".req_wait"}, {31'd0, biu_req}, 32'd1);
         chk({t, ".baddr_wait"}, biu_addr, v.baddr);
      end
      biu_ack   = 1'b1;
      biu_rdata = v.rdata;
      biu_err   = v.err;
      step();
      biu_ack   = 1'b0;
      biu_err   = 1'b0;
      biu_rdata = 32'h0;
      chk({t, ".dv"},     {31'd0, lsu_data_valid_ls3}, {31'd0, ~st});
      chk({t, ".wrfin"},  {31'd0, lsu_wr_fin_ls3}, {31'd0, st});
      chk({t, ".buserr"}, {31'd0, lsu_except_buserr_ls3}, {31'd0, v.err});
      chk({t, ".req_ls3"}, {31'd0, biu_req}, 32'd0);
      if (!st) begin
         chk({t, ".rdata"}, lsu_rdata_ls3, v.erdata);
         chk({t, ".rd"}, {27'd0, lsu_rd_ls3}, {27'd0, v.rd});
      end
      step();
      chk({t, ".pulse_once"}, {30'd0, lsu_data_valid_ls3, lsu_wr_fin_ls3}, 32'd0);
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd,
                               input logic [31:0] rdata, input logic err, input int waits,
                               input logic ale, input logic [31:0] baddr, input logic [3:0] strb,
                               input logic [31:0] bwdata, input logic [31:0] erdata);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
      v.err = err; v.waits = waits; v.ale = ale; v.baddr = baddr; v.strb = strb;
      v.bwdata = bwdata; v.erdata = erdata;
      return v;
   endfunction

   initial begin
      // op: {store, unsigned, size}
      vecs[0]  = mk(4'b0010, 32'h0000_1000, 32'h0,         5'd5,  32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,         32'hDEAD_BEEF);
      vecs[1]  = mk(4'b0000, 32'h0000_1003, 32'h0,         5'd7,  32'h8012_3456, 1'b0, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,         32'hFFFF_FF80);
      vecs[2]  = mk(4'b0100, 32'h0000_1003, 32'h0,         5'd8,  32'h8012_3456, 1'b0, 1, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,         32'h0000_0080);
      vecs[3]  = mk(4'b1001, 32'h0000_2002, 32'hABCD_1234, 5'd0,  32'h0,         1'b0, 3, 1'b0, 32'h0000_2000, 4'b1100, 32'h1234_1234, 32'h0);
      vecs[4]  = mk(4'b0010, 32'h0000_1001, 32'h0,         5'd3,  32'h0,         1'b0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0);
      vecs[5]  = mk(4'b0001, 32'h0000_1002, 32'h0,         5'd9,  32'h5555_AAAA, 1'b1, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,         32'h0);
      vecs[6]  = mk(4'b1000, 32'h0000_3001, 32'h1234_56A5, 5'd0,  32'h0,         1'b0, 0, 1'b0, 32'h0000_3000, 4'b0010, 32'hA5A5_A5A5, 32'h0);
      vecs[7]  = mk(4'b0001, 32'h0000_1000, 32'h0,         5'd10, 32'h1234_F00D, 1'b0, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,         32'hFFFF_F00D);
      vecs[8]  = mk(4'b0101, 32'h0000_1002, 32'h0,         5'd11, 32'h8001_0000, 1'b0, 2, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,         32'h0000_8001);
      vecs[9]  = mk(4'b0001, 32'h0000_1003, 32'h0,         5'd12, 32'h0,         1'b0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0);
      vecs[10] = mk(4'b1010, 32'h0000_4000, 32'hCAFE_F00D, 5'd0,  32'h0,         1'b0, 0, 1'b0, 32'h0000_4000, 4'b1111, 32'hCAFE_F00D, 32'h0);
      vecs[11] = mk(4'b0011, 32'h0000_4002, 32'h0,         5'd13, 32'h0,         1'b0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0);
      vecs[12] = mk(4'b0011, 32'h0000_5000, 32'h0,         5'd14, 32'h1122_3344, 1'b0, 0, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,         32'h1122_3344);
      vecs[13] = mk(4'b1000, 32'h0000_3003, 32'h0000_003C, 5'd0,  32'h0,         1'b0, 0, 1'b0, 32'h0000_3000, 4'b1000, 32'h3C3C_3C3C, 32'h0);
      vecs[14] = mk(4'b1010, 32'h0000_6008, 32'h0BAD_0BAD, 5'd0,  32'h0,         1'b1, 1, 1'b0, 32'h0000_6008, 4'b1111, 32'h0BAD_0BAD, 32'h0);

      resetn = 1'b0; lsu_vld_e = 1'b0; lsu_op_e = '0; lsu_addr_e = '0;
      lsu_wdata_e = '0; lsu_rd_e = '0; biu_ack = 1'b0; biu_rdata = '0; biu_err = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      resetn = 1'b1;
      step();

      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // Stray ack in IDLE must not produce a completion.
      biu_ack = 1'b1; biu_rdata = 32'hFFFF_FFFF;
      step();
      biu_ack = 1'b0;
      chk("stray_ack.pulse", {30'd0, lsu_data_valid_ls3, lsu_wr_fin_ls3}, 32'd0);
      chk("stray_ack.req", {31'd0, biu_req}, 32'd0);

      // Back-to-back: SW then LW issued in the SW's LS3 cycle.
      issue(4'b1010, 32'h0000_7000, 32'h0102_0304, 5'd0);
      step();
      lsu_vld_e = 1'b0;
      step();
      chk("b2b.req1", {31'd0, biu_req}, 32'd1);
      biu_ack = 1'b1;
      step();
      biu_ack = 1'b0;
      chk("b2b.wrfin", {31'd0, lsu_wr_fin_ls3}, 32'd1);
      issue(4'b0010, 32'h0000_7004, 32'h0, 5'd21);
      step();
      lsu_vld_e = 1'b0;
      chk("b2b.ls1_req", {31'd0, biu_req}, 32'd0);
      step();
      chk("b2b.req2", {31'd0, biu_req}, 32'd1);
      chk("b2b.addr2", biu_addr, 32'h0000_7004);
      chk("b2b.wr2", {31'd0, biu_wr}, 32'd0);
      biu_ack = 1'b1; biu_rdata = 32'h7777_0001;
      step();
      biu_ack = 1'b0;
      chk("b2b.dv", {31'd0, lsu_data_valid_ls3}, 32'd1);
      chk("b2b.rdata", lsu_rdata_ls3, 32'h7777_0001);
      chk("b2b.rd", {27'd0, lsu_rd_ls3}, 32'd21);
      step();

      // Reset asserted while the request is outstanding.
      issue(4'b1010, 32'h0000_8000, 32'h1357_9BDF, 5'd2);
      step();
      lsu_vld_e = 1'b0;
      step();
      chk("rst_ls2.req_before", {31'd0, biu_req}, 32'd1);
      resetn = 1'b0;
      #1;
      chk_all_zero("rst_ls2");
      step();
      resetn = 1'b1;
      biu_ack = 1'b1; biu_rdata = 32'h2468_ACE0;
      step();
      biu_ack = 1'b0;
      chk("rst_ls2.late_ack", {30'd0, lsu_data_valid_ls3, lsu_wr_fin_ls3}, 32'd0);
      chk("rst_ls2.req_after", {31'd0, biu_req}, 32'd0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
